// File: rtl/mos6502s_stack_sequencer.sv
// mos6502s_stack_sequencer: sequences 0..3-byte page-1 stack pushes/pulls (start/op/count/push_data in; sp_inc/sp_dec, mem_* bus, busy/done/pull_data out)
module mos6502s_stack_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [1:0]  count,
  input  logic [23:0] push_data,
  input  logic        rdy,
  input  logic [15:0] sp_addr,
  input  logic [15:0] sp_addr_plus1,
  input  logic [7:0]  mem_rdata,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        busy,
  output logic        done,
  output logic [23:0] pull_data
);
  typedef enum logic [1:0] {IDLE, PUSH, PULL, DRAIN} state_t;
  state_t state, state_n;
  logic [1:0] cnt, idx, cap;
  logic [23:0] sh;
  logic pend, accept, issue, last, done_n;
  always_comb begin
    accept = state == IDLE && start && !done;
    issue = rdy && (state == PUSH || state == PULL);
    last = issue && idx == cnt - 2'd1;
    state_n = state == IDLE ? (accept && count != 2'd0 ? (op ? PULL : PUSH) : IDLE)
            : state == DRAIN ? IDLE
            : last ? (state == PULL ? DRAIN : IDLE) : state;
    done_n = (accept && count == 2'd0) || (last && state == PUSH) || state == DRAIN;
    mem_we = issue && state == PUSH;
    mem_re = issue && state == PULL;
    sp_dec = mem_we;
    sp_inc = mem_re;
    mem_addr = mem_we ? sp_addr : mem_re ? sp_addr_plus1 : 16'h0;
    mem_wdata = mem_we ? sh[23:16] : 8'h0;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= done_n;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= 2'd0;
      idx <= 2'd0;
      cap <= 2'd0;
      sh <= 24'h0;
      pend <= 1'b0;
      pull_data <= 24'h0;
    end else begin
      pend <= mem_re;
      if (pend) begin
        pull_data[{cap, 3'b000} +: 8] <= mem_rdata;
        cap <= cap + 2'd1;
      end
      if (issue) begin
        idx <= idx + 2'd1;
        sh <= sh << 8;
      end
      if (accept) begin
        cnt <= count;
        idx <= 2'd0;
        cap <= 2'd0;
        sh <= push_data << {2'd3 - count, 3'b000};
        if (op && count != 2'd0) pull_data <= 24'h0;
      end
    end
endmodule

// File: tb/tb_mos6502s_stack_sequencer.sv
// tb_mos6502s_stack_sequencer: table-driven, hand-sequenced and random checks against a stack/memory reference model
module tb_mos6502s_stack_sequencer;
  logic clk = 1'b0, rst, start, op, rdy;
  logic [1:0] count;
  logic [23:0] push_data, pull_data;
  logic [15:0] sp_addr, sp_addr_plus1, mem_addr;
  logic [7:0] mem_rdata, mem_wdata;
  logic sp_inc, sp_dec, mem_we, mem_re, busy, done;
  logic [7:0] sp, ld_sp;
  logic ld, ld_mem;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] ref_sp;
  logic [23:0] ref_pd;
  int tests = 0, fails = 0, inv_err = 0;

  mos6502s_stack_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .count(count), .push_data(push_data),
    .rdy(rdy), .sp_addr(sp_addr), .sp_addr_plus1(sp_addr_plus1), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .pull_data(pull_data)
  );

  always #5 clk = ~clk;

  assign sp_addr = {8'h01, sp};
  assign sp_addr_plus1 = {8'h01, sp + 8'd1};

  always @(posedge clk) begin
    if (ld) sp <= ld_sp;
    else if (sp_inc) sp <= sp + 8'd1;
    else if (sp_dec) sp <= sp - 8'd1;
    if (ld_mem) for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
    else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem_re ? mem[mem_addr[7:0]] : 8'($urandom);
  end

  always @(negedge clk) begin
    #1;
    if ((sp_inc && sp_dec) || (mem_we && mem_re) || (done && busy) ||
        ((!busy || !rdy) && (sp_inc || sp_dec || mem_we || mem_re))) begin
      inv_err++;
      $display("FAIL invariant at %0t: inc=%b dec=%b we=%b re=%b busy=%b done=%b rdy=%b",
               $time, sp_inc, sp_dec, mem_we, mem_re, busy, done, rdy);
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic xact(input bit o, input logic [1:0] c, input logic [23:0] d, input int s_at,
                      input int s_len, input bit spam, input bit has_pd, input logic [23:0] pd);
    logic [15:0] ea [3];
    logic [7:0] ed [3];
    logic [23:0] epd;
    int exp_done, nw, nr, dcyc;
    bit busy_ok;
    epd = (o && c != 2'd0) ? 24'h0 : ref_pd;
    for (int i = 0; i < int'(c); i++) begin
      ed[i] = 8'h0;
      if (o) begin
        ref_sp = ref_sp + 8'd1;
        ea[i] = {8'h01, ref_sp};
        epd[8*i +: 8] = ref_mem[ref_sp];
      end else begin
        ea[i] = {8'h01, ref_sp};
        ed[i] = 8'(d >> (8 * (int'(c) - 1 - i)));
        ref_mem[ref_sp] = ed[i];
        ref_sp = ref_sp - 8'd1;
      end
    end
    ref_pd = epd;
    exp_done = c == 2'd0 ? 1 : int'(c) + (o ? 2 : 1) + ((s_at >= 1 && s_at <= int'(c)) ? s_len : 0);
    @(negedge clk);
    start = 1'b1; op = o; count = c; push_data = d; rdy = 1'b1;
    dcyc = 0; nw = 0; nr = 0; busy_ok = 1'b1;
    for (int cyc = 1; cyc <= 30 && dcyc == 0; cyc++) begin
      @(negedge clk);
      start = spam;
      if (spam) begin op = 1'($urandom); count = 2'($urandom); push_data = 24'($urandom); end
      rdy = !(cyc >= s_at && cyc < s_at + s_len);
      #1;
      if (mem_we) begin
        if (nw < 3) begin chk("wr_addr", 32'(mem_addr), 32'(ea[nw])); chk("wr_data", 32'(mem_wdata), 32'(ed[nw])); end
        nw++;
      end
      if (mem_re) begin
        if (nr < 3) chk("rd_addr", 32'(mem_addr), 32'(ea[nr]));
        nr++;
      end
      if (done) begin
        dcyc = cyc;
        chk("pull_data", 32'(pull_data), 32'(epd));
        if (has_pd) chk("pull_data_const", 32'(pull_data), 32'(pd));
      end else if (!busy) busy_ok = 1'b0;
    end
    rdy = 1'b1;
    if (spam) begin
      start = 1'b1; count = 2'd3;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("start_in_done_ignored", {30'h0, busy, done}, 32'h0);
    end else start = 1'b0;
    chk("done_cycle", dcyc, exp_done);
    chk("writes", nw, o ? 0 : int'(c));
    chk("reads", nr, o ? int'(c) : 0);
    chk("busy_window", 32'(busy_ok), 32'h1);
    chk("sp", 32'(sp), 32'(ref_sp));
  endtask

  typedef struct {
    bit ld; logic [7:0] spv; bit o; logic [1:0] c; logic [23:0] d;
    int s_at; int s_len; bit spam; bit has_pd; logic [23:0] pd;
  } vec_t;
  vec_t tab [9];

  initial begin
    tab[0] = '{1'b1, 8'hFD, 1'b0, 2'd3, 24'h1234B4, 0, 0, 1'b0, 1'b0, 24'h0};
    tab[1] = '{1'b0, 8'h00, 1'b1, 2'd3, 24'h0,      0, 0, 1'b0, 1'b1, 24'h1234B4};
    tab[2] = '{1'b1, 8'h00, 1'b0, 2'd2, 24'h00AABB, 0, 0, 1'b0, 1'b0, 24'h0};
    tab[3] = '{1'b0, 8'h00, 1'b1, 2'd2, 24'h0,      0, 0, 1'b0, 1'b1, 24'h00AABB};
    tab[4] = '{1'b0, 8'h00, 1'b0, 2'd2, 24'h00C0DE, 0, 0, 1'b0, 1'b0, 24'h0};
    tab[5] = '{1'b0, 8'h00, 1'b1, 2'd2, 24'h0,      2, 2, 1'b0, 1'b1, 24'h00C0DE};
    tab[6] = '{1'b0, 8'h00, 1'b0, 2'd1, 24'h000077, 0, 0, 1'b1, 1'b0, 24'h0};
    tab[7] = '{1'b0, 8'h00, 1'b1, 2'd0, 24'h0,      0, 0, 1'b0, 1'b1, 24'h00C0DE};
    tab[8] = '{1'b0, 8'h00, 1'b0, 2'd0, 24'hFFFFFF, 0, 0, 1'b1, 1'b0, 24'h0};
    rst = 1'b1; start = 1'b0; op = 1'b0; count = 2'd0; push_data = 24'h0; rdy = 1'b1;
    ld = 1'b1; ld_sp = 8'hFD; ld_mem = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
    ref_sp = 8'hFD; ref_pd = 24'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0); chk("rst_done", 32'(done), 0); chk("rst_pull_data", 32'(pull_data), 0);
    chk("rst_we", 32'(mem_we), 0); chk("rst_re", 32'(mem_re), 0); chk("rst_inc", 32'(sp_inc), 0);
    chk("rst_dec", 32'(sp_dec), 0); chk("rst_addr", 32'(mem_addr), 0); chk("rst_wdata", 32'(mem_wdata), 0);
    @(negedge clk);
    rst = 1'b0; ld = 1'b0; ld_mem = 1'b0;
    for (int t = 0; t < 9; t++) begin
      if (tab[t].ld) begin
        @(negedge clk); ld = 1'b1; ld_sp = tab[t].spv;
        @(negedge clk); ld = 1'b0;
        ref_sp = tab[t].spv;
      end
      xact(tab[t].o, tab[t].c, tab[t].d, tab[t].s_at, tab[t].s_len, tab[t].spam, tab[t].has_pd, tab[t].pd);
    end
    @(negedge clk);
    start = 1'b1; op = 1'b0; count = 2'd3; push_data = 24'hA1B2C3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0); chk("abort_we", 32'(mem_we), 0); chk("abort_dec", 32'(sp_dec), 0);
    chk("abort_addr", 32'(mem_addr), 0); chk("abort_pull_data", 32'(pull_data), 0);
    chk("abort_sp", 32'(sp), 32'(ref_sp - 8'd1));
    chk("abort_mem", 32'(mem[ref_sp]), 32'hA1);
    ref_mem[ref_sp] = 8'hA1; ref_sp = ref_sp - 8'd1; ref_pd = 24'h0;
    @(negedge clk);
    rst = 1'b0;
    xact(1'b0, 2'd3, 24'h5A6B7C, 0, 0, 1'b0, 1'b0, 24'h0);
    xact(1'b1, 2'd3, 24'h0, 0, 0, 1'b0, 1'b1, 24'h5A6B7C);
    for (int r = 0; r < 40; r++)
      xact(1'($urandom), 2'($urandom), 24'($urandom), 1 + int'($urandom_range(0, 2)),
           int'($urandom_range(0, 2)), $urandom_range(0, 3) == 0, 1'b0, 24'h0);
    chk("invariants", inv_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
